ballot_tally_bank: RTL



---
 rtl/evm_pkg.sv | 16 +
 rtl/sat_counter.sv | 33 +++
 rtl/ballot_tally_bank.sv | 129 ++++++++++++
 3 files changed

// File: rtl/evm_pkg.sv
// Shared types for the EVM ballot datapath.
// Poll-session state encoding and counter saturation helper.
package evm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OPEN   = 2'd1,
    COMMIT = 2'd2,
    CLOSED = 2'd3
  } poll_state_t;

  function automatic logic [31:0] sat_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Holds at all-ones; at_max flags the held value.
module sat_counter
  import evm_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         at_max
);

  localparam logic [W-1:0] MAX = W'(sat_max(W));

  logic [W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (inc && !at_max) begin
      count_q <= count_q + W'(1);
    end
  end

  assign count  = count_q;
  assign at_max = (count_q == MAX);

endmodule

// File: rtl/ballot_tally_bank.sv
// Multi-candidate ballot store: saturating tallies behind a
// poll-session FSM, readable only once the poll is closed.
module ballot_tally_bank
  import evm_pkg::*;
#(
  parameter int NUM_CANDIDATES = 8,
  parameter int CAND_W         = 4,
  parameter int COUNT_W        = 8,
  parameter int TOTAL_W        = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               poll_open,
  input  logic               poll_close,
  input  logic               clear,
  input  logic               vote_valid,
  input  logic [CAND_W-1:0]  vote_candidate,
  output logic               vote_ready,
  input  logic [CAND_W-1:0]  rd_addr,
  output logic [COUNT_W-1:0] rd_count,
  output logic [TOTAL_W-1:0] total_votes,
  output logic [TOTAL_W-1:0] rejected_votes,
  output logic [CAND_W-1:0]  last_candidate,
  output logic               saturated,
  output logic [1:0]         poll_state
);

  localparam logic [CAND_W:0] NUM_C = (CAND_W+1)'(NUM_CANDIDATES);

  poll_state_t         state_q;
  logic [CAND_W-1:0]   last_q;
  logic [COUNT_W-1:0]  rd_count_q;
  logic [COUNT_W-1:0]  rd_sel;
  logic                accept;
  logic                in_range;
  logic                clr_all;
  logic                total_max;
  logic                rej_max;

  logic [COUNT_W-1:0]        tally [NUM_CANDIDATES];
  logic [NUM_CANDIDATES-1:0] tally_max;

  // close beats a same-cycle vote
  assign vote_ready = (state_q == OPEN) && !poll_close;
  assign accept     = vote_valid && vote_ready;
  assign in_range   = ({1'b0, vote_candidate} < NUM_C);
  assign clr_all    = clear && (state_q == CLOSED);

  for (genvar i = 0; i < NUM_CANDIDATES; i++) begin : g_tally
    sat_counter #(.W(COUNT_W)) u_tally (
      .clk    (clk),
      .rst_n  (rst_n),
      .inc    (accept && in_range &&
               (vote_candidate == CAND_W'(i))),
      .clr    (clr_all),
      .count  (tally[i]),
      .at_max (tally_max[i])
    );
  end

  sat_counter #(.W(TOTAL_W)) u_total (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (accept && in_range),
    .clr    (clr_all),
    .count  (total_votes),
    .at_max (total_max)
  );

  sat_counter #(.W(TOTAL_W)) u_rejected (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (accept && !in_range),
    .clr    (clr_all),
    .count  (rejected_votes),
    .at_max (rej_max)
  );

  // counters only fall on clear/reset, so the OR is sticky
  assign saturated = (|tally_max) || total_max || rej_max;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (poll_open) state_q <= OPEN;
        OPEN: begin
          if (poll_close)  state_q <= CLOSED;
          else if (accept) state_q <= COMMIT;
        end
        COMMIT:  state_q <= OPEN;
        CLOSED:  if (clear) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= '0;
    end else if (clr_all) begin
      last_q <= '0;
    end else if (accept && in_range) begin
      last_q <= vote_candidate;
    end
  end

  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NUM_CANDIDATES; i++) begin
      if (rd_addr == CAND_W'(i)) rd_sel = tally[i];
    end
  end

  // tallies stay secret until the poll is closed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_count_q <= '0;
    end else begin
      rd_count_q <= (state_q == CLOSED) ? rd_sel : '0;
    end
  end

  assign rd_count       = rd_count_q;
  assign last_candidate = last_q;
  assign poll_state     = state_q;

endmodule
